rtf65002_insn_queue: RTL and testbench
======================================

Name: rtf65002_insn_queue

Overview:
Instruction prefetch queue between the 32-bit instruction fetch bus and the decoder/PC-increment logic.
- Fetches aligned 32-bit words into a byte-wide circular buffer.
- Presents the next 7 instruction bytes (opcode plus up to 6 operand bytes) to the decoder.
- Retires a decoder-supplied byte count (the instruction length, 1..7) each time an instruction is consumed.
- A flush redirects fetch to a new byte address on taken branches, jumps and interrupts.

Parameters:
DEPTH, 16, queue capacity in bytes; power of two, minimum 8.
RESET_PC, 32'hFFFFFFF0, byte address that fetch and pc start from after reset.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
fetch_req_o  out  1  word fetch request; held high until fetch_ack_i
fetch_adr_o  out  32  word-aligned fetch byte address; [1:0]=0
fetch_ack_i  in  1  fetch data valid this cycle
fetch_dat_i  in  32  fetched word, little-endian; byte 0 = [7:0]
flush_i  in  1  discard queue, restart at flush_pc_i
flush_pc_i  in  32  new byte address
ir_o  out  56  next 7 queued bytes; byte 0 (opcode) = [7:0]
avail_o  out  5  valid bytes in queue (0..DEPTH)
pc_o  out  32  byte address of ir_o[7:0]
adv_i  in  1  consume adv_len_i bytes
adv_len_i  in  4  bytes to consume (0..7)
adv_err_o  out  1  one-cycle pulse: adv_i rejected

Behaviour:
Reset (rst_i=1 at a clock edge):
- count=0, rd/wr pointers=0, pc_o=RESET_PC, fetch_adr_o={RESET_PC[31:2],2'b00}, skip=RESET_PC[1:0].
- fetch_req_o=0, adv_err_o=0, drop flag clear.
- Reset overrides flush and adv in the same cycle.

Fetch FSM, states IDLE and WAIT:
- IDLE->WAIT when (DEPTH - count) >= 4 and flush_i=0. fetch_req_o=1 from the next cycle.
- Only one request outstanding. fetch_adr_o is stable while in WAIT.
- WAIT + fetch_ack_i:
  - Write bytes skip..3 of fetch_dat_i to the queue at wr.
  - wr and count advance by 4-skip; then skip=0.
  - fetch_adr_o += 4; return to IDLE.
  - If free space is still >= 4, re-request the next cycle. Sustained rate is 1 word per 2 cycles minimum.

Drain side:
- ir_o byte k = queue[(rd+k) mod DEPTH], combinational from current state. Bytes at k >= avail_o are don't-care.
- adv_i=1 and adv_len_i <= count: rd += adv_len_i, pc_o += adv_len_i, count -= adv_len_i.
- adv_i=1 and adv_len_i > count: no state change; adv_err_o=1 the next cycle.
- adv_len_i=0 is a no-op with no error.

Simultaneous ack and adv:
- count_next = count + written - adv_len_i.
- The free-space check for the new request uses the registered count.

Flush:
- count=0, rd=wr=0, pc_o=flush_pc_i, fetch_adr_o={flush_pc_i[31:2],2'b00}, skip=flush_pc_i[1:0].
- flush_i has priority over adv_i and ack data in the same cycle.
- Flush while in WAIT:
  - fetch_req_o and fetch_adr_o stay held until ack (bus protocol is not abandoned).
  - drop flag set; the returning word is discarded.
  - After the ack, FSM goes to IDLE and the new address is requested the following cycle.
  - The new address is latched in a pending register.

Wrap-around:
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- pc_o wraps modulo 2^32; fetch_adr_o wraps from FFFFFFFC to 0.

Full/empty:
- No request is issued when free space < 4.
- avail_o=0: any adv_i with a nonzero length errors.

Test Plan:
- Reset, ack each request with 1 cycle latency, data 0x44332211, 0x88776655 -> fetch_adr_o FFFFFFF0, FFFFFFF4; avail_o=8; ir_o[55:0]=0x77665544332211; pc_o=FFFFFFF0.
- adv_i with adv_len_i=3 after fill -> pc_o=FFFFFFF3, avail_o=5, ir_o[7:0]=0x44; adv_len_i=6 next -> adv_err_o pulses, state unchanged.
- flush_pc_i=0x00001002 while IDLE, ack 0xDDCCBBAA -> fetch_adr_o=0x00001000; avail_o=2; ir_o[15:0]=0xDDCC; pc_o=0x1002.
- Flush during WAIT, ack delayed 3 cycles -> stale word not queued (avail_o stays 0); next request at the flush address.
- Continuous ack with no adv -> fill stops at avail_o=16, fetch_req_o=0; adv_len_i=4 -> request resumes, pointers wrap, byte order preserved.
- Same-cycle ack (4 bytes) and adv_len_i=2 with count=5 -> avail_o=7; rst_i asserted mid-WAIT -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/rtf65002_insn_queue_if.sv
// Instruction fetch bus between the prefetch queue and the memory side.
//   fetch_req_o  : word fetch request, held until fetch_ack_i
//   fetch_adr_o  : word-aligned fetch byte address
//   fetch_ack_i  : fetch data valid this cycle
//   fetch_dat_i  : fetched word, little-endian
// master = prefetch queue, slave = memory/bus responder.
interface rtf65002_insn_queue_if;
    logic        fetch_req_o;
    logic [31:0] fetch_adr_o;
    logic        fetch_ack_i;
    logic [31:0] fetch_dat_i;

    modport master (
        output fetch_req_o,
        output fetch_adr_o,
        input  fetch_ack_i,
        input  fetch_dat_i
    );

    modport slave (
        input  fetch_req_o,
        input  fetch_adr_o,
        output fetch_ack_i,
        output fetch_dat_i
    );
endinterface

// File: rtl/rtf65002_insn_queue.sv
// Instruction prefetch queue: fetches aligned 32-bit words into a byte-wide
// circular buffer and presents the next 7 bytes to the decoder.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   fbus             : fetch bus (request/address out, ack/data in)
//   flush_i/pc_i     : discard queue and restart fetch at a new byte address
//   ir_o             : next 7 queued bytes, opcode in [7:0]
//   avail_o          : valid bytes in queue
//   pc_o             : byte address of ir_o[7:0]
//   adv_i/adv_len_i  : consume adv_len_i bytes
//   adv_err_o        : one-cycle pulse when an advance was rejected
module rtf65002_insn_queue #(
    parameter int unsigned DEPTH    = 16,
    parameter logic [31:0] RESET_PC = 32'hFFFFFFF0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    rtf65002_insn_queue_if.master       fbus,
    input  logic                        flush_i,
    input  logic [31:0]                 flush_pc_i,
    output logic [55:0]                 ir_o,
    output logic [4:0]                  avail_o,
    output logic [31:0]                 pc_o,
    input  logic                        adv_i,
    input  logic [3:0]                  adv_len_i,
    output logic                        adv_err_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]    r_state;
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_pc;
    logic [31:0]   r_adr;
    logic [31:0]   r_pend;
    logic [1:0]    r_skip;
    logic          r_drop;
    logic          r_err;
    logic [7:0]    r_mem [DEPTH];

    logic          w_ack;
    logic          w_wr_en;
    logic          w_free_ok;
    logic          w_adv_ok;
    logic          w_adv_bad;
    logic [2:0]    w_nbytes;
    logic [55:0]   w_ir;

    assign w_ack     = (r_state == S_WAIT) && fbus.fetch_ack_i;
    assign w_wr_en   = w_ack && !flush_i && !r_drop && !rst_i;
    assign w_free_ok = (CW'(DEPTH) - r_count) >= CW'(4);
    assign w_adv_ok  = adv_i && (CW'(adv_len_i) <= r_count);
    assign w_adv_bad = adv_i && (CW'(adv_len_i) > r_count);
    assign w_nbytes  = 3'd4 - {1'b0, r_skip};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_pc    <= RESET_PC;
            r_adr   <= {RESET_PC[31:2], 2'b00};
            r_pend  <= '0;
            r_skip  <= RESET_PC[1:0];
            r_drop  <= 1'b0;
            r_err   <= 1'b0;
        end else if (flush_i) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_pc    <= flush_pc_i;
            r_skip  <= flush_pc_i[1:0];
            r_err   <= 1'b0;
            if (r_state == S_WAIT) begin
                // The bus cycle in flight must complete; its word is
                // discarded and the new address is issued afterwards.
                if (fbus.fetch_ack_i) begin
                    r_state <= S_IDLE;
                    r_adr   <= {flush_pc_i[31:2], 2'b00};
                    r_drop  <= 1'b0;
                end else begin
                    r_drop  <= 1'b1;
                    r_pend  <= {flush_pc_i[31:2], 2'b00};
                end
            end else begin
                r_adr <= {flush_pc_i[31:2], 2'b00};
            end
        end else begin
            r_err   <= w_adv_bad;
            r_count <= r_count + (w_wr_en ? CW'(w_nbytes) : '0)
                               - (w_adv_ok ? CW'(adv_len_i) : '0);
            if (w_adv_ok) begin
                r_rd <= r_rd + PW'(adv_len_i);
                r_pc <= r_pc + 32'(adv_len_i);
            end
            case (r_state)
                S_IDLE: begin
                    if (w_free_ok) r_state <= S_WAIT;
                end
                default: begin
                    if (w_ack) begin
                        r_state <= S_IDLE;
                        if (r_drop) begin
                            r_drop <= 1'b0;
                            r_adr  <= r_pend;
                        end else begin
                            r_wr   <= r_wr + PW'(w_nbytes);
                            r_adr  <= r_adr + 32'd4;
                            r_skip <= 2'b00;
                        end
                    end
                end
            endcase
        end
    end

    // Bytes skip..3 of the word land contiguously starting at r_wr.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            for (int unsigned j = 0; j < 4; j++) begin
                if (j >= 32'(r_skip))
                    r_mem[PW'(32'(r_wr) + j - 32'(r_skip))] <= fbus.fetch_dat_i[8*j +: 8];
            end
        end
    end

    always_comb begin
        w_ir = '0;
        for (int unsigned k = 0; k < 7; k++)
            w_ir[8*k +: 8] = r_mem[PW'(32'(r_rd) + k)];
    end

    assign ir_o             = w_ir;
    assign avail_o          = 5'(r_count);
    assign pc_o             = r_pc;
    assign adv_err_o        = r_err;
    assign fbus.fetch_req_o = (r_state == S_WAIT);
    assign fbus.fetch_adr_o = r_adr;
endmodule

// File: tb/tb_rtf65002_insn_queue.sv
// Self-checking bench for rtf65002_insn_queue: directed scenarios plus a
// randomized run checked against a byte-queue reference model.
module tb_rtf65002_insn_queue;
    localparam logic [31:0] RPC = 32'hFFFFFFF0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] fpc = '0;
    logic        adv = 1'b0;
    logic [3:0]  len = '0;
    logic [55:0] ir;
    logic [4:0]  avail;
    logic [31:0] pc;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;

    rtf65002_insn_queue_if fbus();

    rtf65002_insn_queue #(.DEPTH(16), .RESET_PC(RPC)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .fbus       (fbus.master),
        .flush_i    (flush),
        .flush_pc_i (fpc),
        .ir_o       (ir),
        .avail_o    (avail),
        .pc_o       (pc),
        .adv_i      (adv),
        .adv_len_i  (len),
        .adv_err_o  (err)
    );

    always #5 clk = ~clk;

    // Reference model: the queue is a plain byte queue.
    logic [7:0]  mq[$];
    logic [31:0] m_pc, m_adr, m_pend;
    logic [1:0]  m_skip;
    bit          m_req, m_stale, m_err;

    task automatic model_update();
        int sz = mq.size();
        if (rst) begin
            mq.delete();
            m_pc = RPC; m_adr = {RPC[31:2], 2'b00}; m_skip = RPC[1:0];
            m_req = 0; m_stale = 0; m_err = 0;
        end else if (flush) begin
            mq.delete();
            m_pc = fpc; m_skip = fpc[1:0]; m_err = 0;
            if (m_req && fbus.fetch_ack_i) begin
                m_req = 0; m_stale = 0; m_adr = {fpc[31:2], 2'b00};
            end else if (m_req) begin
                m_stale = 1; m_pend = {fpc[31:2], 2'b00};
            end else begin
                m_adr = {fpc[31:2], 2'b00};
            end
        end else begin
            m_err = 0;
            if (adv && len != 0) begin
                if (int'(len) <= sz) begin
                    for (int i = 0; i < int'(len); i++) void'(mq.pop_front());
                    m_pc = m_pc + 32'(len);
                end else begin
                    m_err = 1;
                end
            end
            if (m_req && fbus.fetch_ack_i) begin
                if (m_stale) begin
                    m_stale = 0; m_adr = m_pend;
                end else begin
                    for (int j = int'(m_skip); j < 4; j++) mq.push_back(fbus.fetch_dat_i[8*j +: 8]);
                    m_adr = m_adr + 32'd4; m_skip = 0;
                end
                m_req = 0;
            end else if (!m_req && (16 - sz) >= 4) begin
                m_req = 1;
            end
        end
    endtask

    function automatic logic [55:0] exp_ir();
        logic [55:0] v = '0;
        for (int k = 0; k < 7 && k < mq.size(); k++) v[8*k +: 8] = mq[k];
        return v;
    endfunction

    function automatic logic [55:0] exp_mask();
        logic [55:0] v = '0;
        for (int k = 0; k < 7 && k < mq.size(); k++) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 8 && fbus.fetch_req_o !== 1'b1; i++) tick();
        n_cmp++;
        if (fbus.fetch_req_o !== 1'b1) begin
            n_fail++; $display("FAIL wait_req: fetch_req_o=%b required 1 within 8 cycles", fbus.fetch_req_o);
        end
    endtask

    task automatic test_reset();
        rst = 1; tick(); tick(); rst = 0;
        n_cmp++; if (fbus.fetch_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", fbus.fetch_req_o); end
        n_cmp++; if (fbus.fetch_adr_o !== 32'hFFFFFFF0) begin n_fail++; $display("FAIL reset_adr: got %h want fffffff0", fbus.fetch_adr_o); end
        n_cmp++; if (pc !== 32'hFFFFFFF0) begin n_fail++; $display("FAIL reset_pc: got %h want fffffff0", pc); end
        n_cmp++; if (avail !== 5'd0) begin n_fail++; $display("FAIL reset_avail: got %0d want 0", avail); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        adv = 1; len = 4'd1; tick(); adv = 0; len = 0;
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL empty_adv_err: got %b want 1", err); end
    endtask

    task automatic test_fill();
        wait_req();
        n_cmp++; if (fbus.fetch_adr_o !== 32'hFFFFFFF0) begin n_fail++; $display("FAIL fill_adr0: got %h want fffffff0", fbus.fetch_adr_o); end
        fbus.fetch_ack_i = 1; fbus.fetch_dat_i = 32'h44332211; tick(); fbus.fetch_ack_i = 0;
        wait_req();
        n_cmp++; if (fbus.fetch_adr_o !== 32'hFFFFFFF4) begin n_fail++; $display("FAIL fill_adr1: got %h want fffffff4", fbus.fetch_adr_o); end
        fbus.fetch_ack_i = 1; fbus.fetch_dat_i = 32'h88776655; tick(); fbus.fetch_ack_i = 0;
        n_cmp++; if (avail !== 5'd8) begin n_fail++; $display("FAIL fill_avail: got %0d want 8", avail); end
        n_cmp++; if (ir !== 56'h77665544332211) begin n_fail++; $display("FAIL fill_ir: got %h want 77665544332211", ir); end
        n_cmp++; if (pc !== 32'hFFFFFFF0) begin n_fail++; $display("FAIL fill_pc: got %h want fffffff0", pc); end
    endtask

    task automatic test_adv_err();
        adv = 1; len = 4'd3; tick(); adv = 0;
        n_cmp++; if (pc !== 32'hFFFFFFF3) begin n_fail++; $display("FAIL adv3_pc: got %h want fffffff3", pc); end
        n_cmp++; if (avail !== 5'd5) begin n_fail++; $display("FAIL adv3_avail: got %0d want 5", avail); end
        n_cmp++; if (ir[7:0] !== 8'h44) begin n_fail++; $display("FAIL adv3_ir: got %h want 44", ir[7:0]); end
        adv = 1; len = 4'd6; tick(); adv = 0; len = 0;
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL adv6_err: got %b want 1", err); end
        n_cmp++; if (avail !== 5'd5) begin n_fail++; $display("FAIL adv6_avail: got %0d want 5", avail); end
        n_cmp++; if (pc !== 32'hFFFFFFF3) begin n_fail++; $display("FAIL adv6_pc: got %h want fffffff3", pc); end
        tick();
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_pulse: got %b want 0", err); end
    endtask

    task automatic test_flush_idle();
        wait_req();
        fbus.fetch_ack_i = 1; fbus.fetch_dat_i = $urandom; tick(); fbus.fetch_ack_i = 0;
        flush = 1; fpc = 32'h00001002; tick(); flush = 0;
        n_cmp++; if (avail !== 5'd0) begin n_fail++; $display("FAIL flush_avail: got %0d want 0", avail); end
        wait_req();
        n_cmp++; if (fbus.fetch_adr_o !== 32'h00001000) begin n_fail++; $display("FAIL flush_adr: got %h want 00001000", fbus.fetch_adr_o); end
        fbus.fetch_ack_i = 1; fbus.fetch_dat_i = 32'hDDCCBBAA; tick(); fbus.fetch_ack_i = 0;
        n_cmp++; if (avail !== 5'd2) begin n_fail++; $display("FAIL flush_fill_avail: got %0d want 2", avail); end
        n_cmp++; if (ir[15:0] !== 16'hDDCC) begin n_fail++; $display("FAIL flush_ir: got %h want ddcc", ir[15:0]); end
        n_cmp++; if (pc !== 32'h00001002) begin n_fail++; $display("FAIL flush_pc: got %h want 00001002", pc); end
    endtask

    task automatic test_flush_wait();
        wait_req();
        n_cmp++; if (fbus.fetch_adr_o !== 32'h00001004) begin n_fail++; $display("FAIL fw_adr_pre: got %h want 00001004", fbus.fetch_adr_o); end
        flush = 1; fpc = 32'h00002000; tick(); flush = 0;
        n_cmp++; if (fbus.fetch_req_o !== 1'b1) begin n_fail++; $display("FAIL fw_req_held: got %b want 1", fbus.fetch_req_o); end
        n_cmp++; if (fbus.fetch_adr_o !== 32'h00001004) begin n_fail++; $display("FAIL fw_adr_held: got %h want 00001004", fbus.fetch_adr_o); end
        n_cmp++; if (pc !== 32'h00002000) begin n_fail++; $display("FAIL fw_pc: got %h want 00002000", pc); end
        tick(); tick();
        fbus.fetch_ack_i = 1; fbus.fetch_dat_i = 32'hDEADBEEF; tick(); fbus.fetch_ack_i = 0;
        n_cmp++; if (avail !== 5'd0) begin n_fail++; $display("FAIL fw_stale_avail: got %0d want 0", avail); end
        wait_req();
        n_cmp++; if (fbus.fetch_adr_o !== 32'h00002000) begin n_fail++; $display("FAIL fw_new_adr: got %h want 00002000", fbus.fetch_adr_o); end
        fbus.fetch_ack_i = 1; fbus.fetch_dat_i = 32'h04030201; tick(); fbus.fetch_ack_i = 0;
        n_cmp++; if (avail !== 5'd4) begin n_fail++; $display("FAIL fw_avail: got %0d want 4", avail); end
        n_cmp++; if (ir[31:0] !== 32'h04030201) begin n_fail++; $display("FAIL fw_ir: got %h want 04030201", ir[31:0]); end
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i < 24; i++) begin
            fbus.fetch_ack_i = m_req; fbus.fetch_dat_i = $urandom; tick();
        end
        fbus.fetch_ack_i = 0;
        n_cmp++; if (avail !== 5'd16) begin n_fail++; $display("FAIL full_avail: got %0d want 16", avail); end
        n_cmp++; if (fbus.fetch_req_o !== 1'b0) begin n_fail++; $display("FAIL full_req: got %b want 0", fbus.fetch_req_o); end
        n_cmp++; if ((ir & exp_mask()) !== exp_ir()) begin n_fail++; $display("FAIL full_ir: got %h want %h", ir, exp_ir()); end
        adv = 1; len = 4'd4; tick(); adv = 0; len = 0;
        tick();
        n_cmp++; if (fbus.fetch_req_o !== 1'b1) begin n_fail++; $display("FAIL resume_req: got %b want 1", fbus.fetch_req_o); end
        for (int i = 0; i < 10; i++) begin
            fbus.fetch_ack_i = m_req; fbus.fetch_dat_i = $urandom; tick();
        end
        fbus.fetch_ack_i = 0;
        n_cmp++; if (pc !== 32'h00002004) begin n_fail++; $display("FAIL wrap_pc: got %h want 00002004", pc); end
        for (int r = 0; r < 2; r++) begin
            adv = 1; len = 4'd7; tick(); adv = 0; len = 0;
            n_cmp++; if ((ir & exp_mask()) !== exp_ir() || avail !== 5'(mq.size())) begin
                n_fail++; $display("FAIL wrap_ir: got %h/%0d want %h/%0d", ir, avail, exp_ir(), mq.size());
            end
        end
    endtask

    task automatic test_back_to_back();
        bit hit = 0;
        flush = 1; fpc = 32'h00003003; tick(); flush = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (m_req && !m_stale && mq.size() == 5) hit = 1;
            else begin
                fbus.fetch_ack_i = m_req && (m_stale || mq.size() < 5);
                fbus.fetch_dat_i = $urandom; tick();
            end
        end
        fbus.fetch_ack_i = 0;
        n_cmp++; if (avail !== 5'd5 || fbus.fetch_req_o !== 1'b1) begin n_fail++; $display("FAIL b2b_setup: got avail %0d req %b want 5/1", avail, fbus.fetch_req_o); end
        fbus.fetch_ack_i = 1; fbus.fetch_dat_i = $urandom; adv = 1; len = 4'd2; tick();
        fbus.fetch_ack_i = 0; adv = 0; len = 0;
        n_cmp++; if (avail !== 5'd7) begin n_fail++; $display("FAIL b2b_avail: got %0d want 7", avail); end
        n_cmp++; if (pc !== 32'h00003005) begin n_fail++; $display("FAIL b2b_pc: got %h want 00003005", pc); end
        wait_req();
        rst = 1; tick(); rst = 0;
        n_cmp++; if (fbus.fetch_req_o !== 1'b0 || fbus.fetch_adr_o !== 32'hFFFFFFF0 || pc !== 32'hFFFFFFF0 || avail !== 5'd0 || err !== 1'b0) begin
            n_fail++; $display("FAIL midwait_rst: got req %b adr %h pc %h avail %0d err %b want 0/fffffff0/fffffff0/0/0", fbus.fetch_req_o, fbus.fetch_adr_o, pc, avail, err);
        end
    endtask

    task automatic test_random();
        rst = 1; tick(); rst = 0;
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 24) == 0);
            fpc   = $urandom;
            adv   = ($urandom_range(0, 9) < 4);
            len   = 4'($urandom_range(0, 7));
            fbus.fetch_ack_i = m_req && ($urandom_range(0, 1) == 1);
            fbus.fetch_dat_i = $urandom;
            tick();
            n_cmp++;
            if (avail !== 5'(mq.size()) || pc !== m_pc || err !== m_err || fbus.fetch_req_o !== m_req
                || fbus.fetch_adr_o !== m_adr || (ir & exp_mask()) !== exp_ir()) begin
                n_fail++;
                $display("FAIL rand_%0d: got avail %0d pc %h err %b req %b adr %h ir %h want %0d %h %b %b %h %h",
                         i, avail, pc, err, fbus.fetch_req_o, fbus.fetch_adr_o, ir & exp_mask(),
                         mq.size(), m_pc, m_err, m_req, m_adr, exp_ir());
            end
        end
        rst = 0; flush = 0; adv = 0; len = 0; fbus.fetch_ack_i = 0;
    endtask

    initial begin
        fbus.fetch_ack_i = 0;
        fbus.fetch_dat_i = '0;
        test_reset();
        test_fill();
        test_adv_err();
        test_flush_idle();
        test_flush_wait();
        test_full_wrap();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
